// File: rtl/mult_hilo_ctrl.sv
// Purpose: registers operands for umultiplier, counts its latency, and captures the product into HI/LO.
// Latency: MULTU result lands in HI/LO at edge T0+MULT_LATENCY+1; MTHI/MTLO write at the accepting edge.
// Backpressure: stall = busy & (start | read_req); while busy, start is ignored and must be held by the requester.
module mult_hilo_ctrl #(
  parameter int unsigned MULT_LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        read_req,
  output logic [31:0] mult_a,
  output logic [31:0] mult_b,
  input  logic [63:0] mult_p,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        done,
  output logic        stall
);

  localparam logic [1:0] OP_MULTU = 2'b00;
  localparam logic [1:0] OP_MTHI  = 2'b01;
  localparam logic [1:0] OP_MTLO  = 2'b10;

  // Counter preload; the legal latency range fits in four bits.
  localparam logic [3:0] LAT = 4'(MULT_LATENCY);

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  state_t      state_q;
  logic [3:0]  cnt_q;
  logic [31:0] mult_a_q;
  logic [31:0] mult_b_q;
  logic [31:0] hi_q;
  logic [31:0] lo_q;
  logic        busy_q;
  logic        done_q;

  // Sequencer: accepts one request in IDLE, then waits out the multiplier latency and captures the product.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= 4'd0;
      mult_a_q <= 32'd0;
      mult_b_q <= 32'd0;
      hi_q     <= 32'd0;
      lo_q     <= 32'd0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      // done is a single-cycle pulse unless the capture branch re-arms it.
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            case (op)
              OP_MULTU: begin
                mult_a_q <= rs_val;
                mult_b_q <= rt_val;
                cnt_q    <= LAT;
                busy_q   <= 1'b1;
                state_q  <= WAIT;
              end
              OP_MTHI: hi_q <= rs_val;
              OP_MTLO: lo_q <= rs_val;
              default: ; // reserved opcode: leave all state untouched
            endcase
          end
        end
        WAIT: begin
          // Requests arriving here are ignored; the stall output tells the requester to hold them.
          if (cnt_q != 4'd0) begin
            cnt_q <= cnt_q - 4'd1;
          end else begin
            hi_q    <= mult_p[63:32];
            lo_q    <= mult_p[31:0];
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Stall is combinational so the requester sees it in the same cycle it asks.
  assign stall  = busy_q & (start | read_req);

  assign mult_a = mult_a_q;
  assign mult_b = mult_b_q;
  assign hi     = hi_q;
  assign lo     = lo_q;
  assign busy   = busy_q;
  assign done   = done_q;

endmodule

// File: tb/tb_mult_hilo_ctrl.sv
// Bench for mult_hilo_ctrl with a delay-line model of umultiplier at latency 2.
// Directed vector table, hand-written reset sequences, then random traffic against a reference model.
module tb_mult_hilo_ctrl;

  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        read_req;
  logic [31:0] mult_a;
  logic [31:0] mult_b;
  logic [63:0] mult_p;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        done;
  logic        stall;

  int n_cmp = 0;
  int n_err = 0;

  mult_hilo_ctrl #(.MULT_LATENCY(LAT)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .rs_val(rs_val), .rt_val(rt_val),
    .read_req(read_req), .mult_a(mult_a), .mult_b(mult_b), .mult_p(mult_p),
    .hi(hi), .lo(lo), .busy(busy), .done(done), .stall(stall)
  );

  always #5 clk = ~clk;

  // umultiplier model: product of the registered operands, delayed by LAT edges.
  logic [63:0] pipe [0:LAT-1];
  always @(posedge clk) begin
    pipe[0] <= {32'd0, mult_a} * {32'd0, mult_b};
    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign mult_p = pipe[LAT-1];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic        start;
    logic [1:0]  op;
    logic [31:0] rs;
    logic [31:0] rt;
    logic        rd;
    logic        ex_stall;
    logic [31:0] ex_hi;
    logic [31:0] ex_lo;
    logic        ex_busy;
    logic        ex_done;
  } vec_t;

  vec_t tbl [0:20];

  function automatic vec_t mkv(input logic s, input logic [1:0] o, input logic [31:0] a,
                               input logic [31:0] b, input logic r, input logic xs,
                               input logic [31:0] xh, input logic [31:0] xl,
                               input logic xb, input logic xd);
    vec_t v;
    v.start = s; v.op = o; v.rs = a; v.rt = b; v.rd = r;
    v.ex_stall = xs; v.ex_hi = xh; v.ex_lo = xl; v.ex_busy = xb; v.ex_done = xd;
    return v;
  endfunction

  task automatic drive(input logic s, input logic [1:0] o, input logic [31:0] a,
                       input logic [31:0] b, input logic r);
    start = s; op = o; rs_val = a; rt_val = b; read_req = r;
  endtask

  // Reference model state: architectural values plus edges remaining until capture.
  logic [31:0] m_hi, m_lo, m_a, m_b;
  logic [63:0] m_prod;
  int          m_pend;
  logic        m_done;

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected finish before timeout");
    $fatal(1, "timeout");
  end

  initial begin
    drive(1'b0, 2'b00, 32'd0, 32'd0, 1'b0);
    rst = 1'b1;

    // Directed table (latency 2): stimulus applied before each edge, results checked after it.
    tbl[0]  = mkv(1'b1, 2'b01, 32'h12345678, 32'h0, 1'b0, 1'b0, 32'h12345678, 32'h0,        1'b0, 1'b0);
    tbl[1]  = mkv(1'b1, 2'b10, 32'h9ABCDEF0, 32'h0, 1'b0, 1'b0, 32'h12345678, 32'h9ABCDEF0, 1'b0, 1'b0);
    tbl[2]  = mkv(1'b1, 2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0, 32'h12345678, 32'h9ABCDEF0, 1'b1, 1'b0);
    tbl[3]  = mkv(1'b0, 2'b00, 32'h0, 32'h0, 1'b0, 1'b0, 32'h12345678, 32'h9ABCDEF0, 1'b1, 1'b0);
    tbl[4]  = mkv(1'b0, 2'b00, 32'h0, 32'h0, 1'b0, 1'b0, 32'h12345678, 32'h9ABCDEF0, 1'b1, 1'b0);
    tbl[5]  = mkv(1'b0, 2'b00, 32'h0, 32'h0, 1'b0, 1'b0, 32'hFFFFFFFE, 32'h00000001, 1'b0, 1'b1);
    tbl[6]  = mkv(1'b0, 2'b00, 32'h0, 32'h0, 1'b0, 1'b0, 32'hFFFFFFFE, 32'h00000001, 1'b0, 1'b0);
    tbl[7]  = mkv(1'b1, 2'b00, 32'h3, 32'h5, 1'b0, 1'b0, 32'hFFFFFFFE, 32'h00000001, 1'b1, 1'b0);
    tbl[8]  = mkv(1'b1, 2'b01, 32'hDEADBEEF, 32'h0, 1'b1, 1'b1, 32'hFFFFFFFE, 32'h00000001, 1'b1, 1'b0);
    tbl[9]  = mkv(1'b1, 2'b01, 32'hDEADBEEF, 32'h0, 1'b1, 1'b1, 32'hFFFFFFFE, 32'h00000001, 1'b1, 1'b0);
    tbl[10] = mkv(1'b1, 2'b01, 32'hDEADBEEF, 32'h0, 1'b1, 1'b1, 32'h0, 32'hF, 1'b0, 1'b1);
    tbl[11] = mkv(1'b0, 2'b00, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0, 32'hF, 1'b0, 1'b0);
    tbl[12] = mkv(1'b1, 2'b00, 32'h10000, 32'h10000, 1'b0, 1'b0, 32'h0, 32'hF, 1'b1, 1'b0);
    tbl[13] = mkv(1'b0, 2'b00, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'hF, 1'b1, 1'b0);
    tbl[14] = mkv(1'b0, 2'b00, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'hF, 1'b1, 1'b0);
    tbl[15] = mkv(1'b0, 2'b00, 32'h0, 32'h0, 1'b0, 1'b0, 32'h1, 32'h0, 1'b0, 1'b1);
    tbl[16] = mkv(1'b1, 2'b00, 32'h7, 32'h6, 1'b0, 1'b0, 32'h1, 32'h0, 1'b1, 1'b0);
    tbl[17] = mkv(1'b0, 2'b00, 32'h0, 32'h0, 1'b0, 1'b0, 32'h1, 32'h0, 1'b1, 1'b0);
    tbl[18] = mkv(1'b0, 2'b00, 32'h0, 32'h0, 1'b0, 1'b0, 32'h1, 32'h0, 1'b1, 1'b0);
    tbl[19] = mkv(1'b0, 2'b00, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h2A, 1'b0, 1'b1);
    tbl[20] = mkv(1'b1, 2'b11, 32'h55555555, 32'h1, 1'b0, 1'b0, 32'h0, 32'h2A, 1'b0, 1'b0);

    // Reset values.
    repeat (2) @(posedge clk);
    #1;
    chk("rst_hi", {32'd0, hi}, 64'd0);
    chk("rst_lo", {32'd0, lo}, 64'd0);
    chk("rst_mult_a", {32'd0, mult_a}, 64'd0);
    chk("rst_mult_b", {32'd0, mult_b}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 21; i++) begin
      @(negedge clk);
      drive(tbl[i].start, tbl[i].op, tbl[i].rs, tbl[i].rt, tbl[i].rd);
      #1;
      chk($sformatf("vec%0d_stall", i), {63'd0, stall}, {63'd0, tbl[i].ex_stall});
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d_hi", i), {32'd0, hi}, {32'd0, tbl[i].ex_hi});
      chk($sformatf("vec%0d_lo", i), {32'd0, lo}, {32'd0, tbl[i].ex_lo});
      chk($sformatf("vec%0d_busy", i), {63'd0, busy}, {63'd0, tbl[i].ex_busy});
      chk($sformatf("vec%0d_done", i), {63'd0, done}, {63'd0, tbl[i].ex_done});
    end
    chk("hold_mult_a", {32'd0, mult_a}, 64'd7);
    chk("hold_mult_b", {32'd0, mult_b}, 64'd6);

    // Asynchronous reset mid-cycle, away from any clock edge, with non-zero state present.
    @(negedge clk);
    drive(1'b1, 2'b00, 32'h9, 32'h9, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("arst_hi", {32'd0, hi}, 64'd0);
    chk("arst_lo", {32'd0, lo}, 64'd0);
    chk("arst_mult_a", {32'd0, mult_a}, 64'd0);
    chk("arst_mult_b", {32'd0, mult_b}, 64'd0);
    chk("arst_busy", {63'd0, busy}, 64'd0);
    chk("arst_done", {63'd0, done}, 64'd0);
    chk("arst_stall", {63'd0, stall}, 64'd0);
    @(negedge clk);
    drive(1'b0, 2'b00, 32'd0, 32'd0, 1'b0);
    rst = 1'b0;

    // Reset during a multiply: the stale product must never reach HI/LO.
    @(negedge clk);
    drive(1'b1, 2'b10, 32'hA5A5A5A5, 32'd0, 1'b0);
    @(negedge clk);
    drive(1'b1, 2'b00, 32'h10000, 32'h10000, 1'b0);
    @(posedge clk);
    #1;
    chk("rmm_busy_T0", {63'd0, busy}, 64'd1);
    chk("rmm_lo_T0", {32'd0, lo}, 64'hA5A5A5A5);
    @(negedge clk);
    drive(1'b0, 2'b00, 32'd0, 32'd0, 1'b0);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("rmm_hi", {32'd0, hi}, 64'd0);
    chk("rmm_lo", {32'd0, lo}, 64'd0);
    chk("rmm_busy", {63'd0, busy}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk);
      #1;
      chk($sformatf("rmm_c%0d_done", c), {63'd0, done}, 64'd0);
      chk($sformatf("rmm_c%0d_hilo", c), {hi, lo}, 64'd0);
      chk($sformatf("rmm_c%0d_busy", c), {63'd0, busy}, 64'd0);
    end

    // Random traffic against the reference model, starting from a fresh reset.
    @(negedge clk);
    rst = 1'b1;
    #1;
    m_hi = 32'd0; m_lo = 32'd0; m_a = 32'd0; m_b = 32'd0;
    m_prod = 64'd0; m_pend = 0; m_done = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 400; c++) begin
      logic        s, r;
      logic [1:0]  o;
      logic [31:0] a, b;
      @(negedge clk);
      s = ($urandom_range(0, 9) < 6);
      o = 2'($urandom_range(0, 3));
      r = ($urandom_range(0, 3) == 0);
      a = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 255)) : $urandom;
      b = ($urandom_range(0, 3) == 0) ? 32'hFFFFFFFF : $urandom;
      drive(s, o, a, b, r);
      #1;
      chk("rnd_stall", {63'd0, stall}, {63'd0, (m_pend > 0) && (s || r)});
      // Model the edge: a multiply in flight counts down to capture; otherwise an accepted request acts.
      m_done = 1'b0;
      if (m_pend > 0) begin
        m_pend--;
        if (m_pend == 0) begin
          m_hi = m_prod[63:32];
          m_lo = m_prod[31:0];
          m_done = 1'b1;
        end
      end else if (s) begin
        if (o == 2'b00) begin
          m_a = a; m_b = b;
          m_prod = {32'd0, a} * {32'd0, b};
          m_pend = LAT + 1;
        end else if (o == 2'b01) begin
          m_hi = a;
        end else if (o == 2'b10) begin
          m_lo = a;
        end
      end
      @(posedge clk);
      #1;
      chk("rnd_hi", {32'd0, hi}, {32'd0, m_hi});
      chk("rnd_lo", {32'd0, lo}, {32'd0, m_lo});
      chk("rnd_busy", {63'd0, busy}, {63'd0, m_pend > 0});
      chk("rnd_done", {63'd0, done}, {63'd0, m_done});
      chk("rnd_mult_ab", {mult_a, mult_b}, {m_a, m_b});
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
